// File: rtl/csel_accum_20_pkg.sv
// ----------------------------------------------------------------------------
// csel_accum_20_pkg
// Shared definitions for the carry-select accumulator:
//   - state_e     : FSM state encoding (IDLE, ACC, HOLD)
//   - DEF_WIDTH   : default operand / accumulator width
//   - DEF_CNT_W   : default operand-count width
//   - NUM_BLK     : number of carry-select blocks in the adder
//   - blk_lo()    : LSB index of each carry-select block
// ----------------------------------------------------------------------------
package csel_accum_20_pkg;

    localparam int DEF_WIDTH = 20;
    localparam int DEF_CNT_W = 8;

    // Carry-select partition from the LSB: 1,1,2,3,4,5 bits, with the last
    // block taking whatever remains (4 bits at the default width).
    localparam int NUM_BLK = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic int blk_lo(input int idx);
        case (idx)
            0:       blk_lo = 0;
            1:       blk_lo = 1;
            2:       blk_lo = 2;
            3:       blk_lo = 4;
            4:       blk_lo = 7;
            5:       blk_lo = 11;
            default: blk_lo = 16;
        endcase
    endfunction

endpackage

// File: rtl/cs_add20.sv
// ----------------------------------------------------------------------------
// cs_add20
// Purely combinational carry-select adder, WIDTH-bit + WIDTH-bit -> WIDTH+1.
// Each block precomputes its sum for carry-in 0 and 1; the incoming block
// carry selects the result and the outgoing carry.
// Ports:
//   a_i   [WIDTH-1:0] : operand A
//   b_i   [WIDTH-1:0] : operand B
//   sum_o [WIDTH:0]   : A + B, MSB is the carry out
// ----------------------------------------------------------------------------
module cs_add20
    import csel_accum_20_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    // carry[k] is the carry into block k; carry[NUM_BLK] is the final carry.
    logic [NUM_BLK:0] carry;

    assign carry[0] = 1'b0;

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        localparam int LO = blk_lo(k);
        localparam int HI = (k == NUM_BLK - 1) ? WIDTH - 1 : blk_lo(k + 1) - 1;
        localparam int BW = HI - LO + 1;

        logic [BW:0] s0;
        logic [BW:0] s1;

        assign s0 = {1'b0, a_i[HI:LO]} + {1'b0, b_i[HI:LO]};
        assign s1 = {1'b0, a_i[HI:LO]} + {1'b0, b_i[HI:LO]} + {{BW{1'b0}}, 1'b1};

        assign sum_o[HI:LO] = carry[k] ? s1[BW-1:0] : s0[BW-1:0];
        assign carry[k+1]   = carry[k] ? s1[BW]     : s0[BW];
    end

    assign sum_o[WIDTH] = carry[NUM_BLK];

endmodule

// File: rtl/csel_accum_20.sv
// ----------------------------------------------------------------------------
// csel_accum_20
// Accumulates a job of `len` unsigned operands and presents the sum.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never depends on ready, and ready here depends only on
// FSM state (in_ready) or is a plain input (out_ready).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, len            : begin a job of `len` operands (IDLE only)
//   in_valid/in_ready     : operand handshake, in_data is the operand
//   out_valid/out_ready   : result handshake, out_sum/out_ovf the result
//   busy                  : FSM not in IDLE
//   dbg_state_o           : raw FSM state for debug/observation
// ----------------------------------------------------------------------------
module csel_accum_20
    import csel_accum_20_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam bit             SAT_EN  = (SAT != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic [WIDTH:0]   add_sum;
    logic             in_hs;

    cs_add20 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (add_sum)
    );

    // Decoded straight from the state register, so reset clears them at once.
    assign in_ready    = (state_q == ACC);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign out_sum     = acc_q;
    assign out_ovf     = ovf_q;
    assign dbg_state_o = state_q;

    assign in_hs = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    // A zero-length job has nothing to add: go straight to HOLD.
                    state_d = (len == '0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_hs) begin
                    acc_d = (SAT_EN && add_sum[WIDTH]) ? '1 : add_sum[WIDTH-1:0];
                    ovf_d = ovf_q | add_sum[WIDTH];
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // start here is ignored, even on the out_ready cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csel_accum_20.sv
module tb_csel_accum_20;
    import csel_accum_20_pkg::*;

    localparam int W = 20;
    localparam longint MAXV = (64'd1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic         start;
    logic [7:0]   len;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready0, out_valid0, out_ovf0, busy0;
    logic [W-1:0] out_sum0;
    logic [1:0]   dbg_state0;
    logic         in_ready1, out_valid1, out_ovf1, busy1;
    logic [W-1:0] out_sum1;
    logic [1:0]   dbg_state1;

    // Wrapping instance and saturating instance share the same stimulus.
    csel_accum_20 #(.WIDTH(W), .CNT_W(8), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_ovf(out_ovf0), .busy(busy0), .dbg_state_o(dbg_state0)
    );

    csel_accum_20 #(.WIDTH(W), .CNT_W(8), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_ovf(out_ovf1), .busy(busy1), .dbg_state_o(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] op_q[$];
    logic [W:0]   exp_q[$];   // {ovf, sum}: wrap result then saturate result

    // Reference: add operands as plain integers, track overflow per step.
    function automatic logic [W:0] model_job(input bit sat);
        longint acc;
        logic   o;
        acc = 0;
        o   = 1'b0;
        foreach (op_q[i]) begin
            acc = acc + longint'(op_q[i]);
            if (acc > MAXV) begin
                o   = 1'b1;
                acc = sat ? MAXV : acc - (MAXV + 1);
            end
        end
        return {o, acc[W-1:0]};
    endfunction

    task automatic push_expect();
        exp_q.push_back(model_job(1'b0));
        exp_q.push_back(model_job(1'b1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    // Feeds op_q; flags a timeout and whether out_valid rose early or late.
    task automatic feed_ops(input bit toggle, input bit pulse_start,
                            output bit timeout, output bit lat_bad);
        int idx;
        int cyc;
        bit hs;
        idx = 0;
        cyc = 0;
        timeout = 1'b0;
        lat_bad = 1'b0;
        while (idx < op_q.size()) begin
            if (cyc >= 300) begin
                timeout = 1'b1;
                break;
            end
            if (out_valid0 !== 1'b0) lat_bad = 1'b1;
            in_valid = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = op_q[idx];
            start    = pulse_start ? ($urandom_range(0, 1) == 1) : 1'b0;
            len      = 8'($urandom_range(1, 255));
            hs = in_valid && (in_ready0 === 1'b1);
            @(negedge clk);
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        len      = '0;
        if (!timeout && out_valid0 !== 1'b1) lat_bad = 1'b1;
    endtask

    task automatic ack(input bit with_start);
        out_ready = 1'b1;
        start     = with_start;
        len       = 8'd3;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        len       = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        #12;
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b vld=%b busy=%b want 0 0 0", in_ready0, out_valid0, busy0);
        end
        checks++;
        if (out_sum0 !== '0 || out_ovf0 !== 1'b0 || dbg_state0 !== 2'(IDLE)) begin
            errors++;
            $display("FAIL reset_vals got sum=%h ovf=%b st=%0d want 0 0 %0d", out_sum0, out_ovf0, dbg_state0, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || in_ready0 !== 1'b0 || out_sum0 !== '0) begin
            errors++;
            $display("FAIL reset_release got busy=%b rdy=%b sum=%h want 0 0 0", busy0, in_ready0, out_sum0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        bit to, lb;
        logic [W:0] e0, e1;
        op_q = '{20'h00001, 20'h00002, 20'h00003};
        push_expect();
        start_job(8'd3);
        checks++;
        if (busy0 !== 1'b1 || in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_acc_state got busy=%b rdy=%b vld=%b want 1 1 0", busy0, in_ready0, out_valid0);
        end
        feed_ops(1'b0, 1'b0, to, lb);
        checks++;
        if (to || lb) begin
            errors++;
            $display("FAIL basic_latency got timeout=%b latency_bad=%b want 0 0", to, lb);
        end
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checks++;
        if ({out_ovf0, out_sum0} !== e0 || {out_ovf1, out_sum1} !== e1) begin
            errors++;
            $display("FAIL basic_sum got %h/%h want %h/%h", {out_ovf0, out_sum0}, {out_ovf1, out_sum1}, e0, e1);
        end
        ack(1'b0);
        checks++;
        if (busy0 !== 1'b0 || out_valid0 !== 1'b0 || out_sum0 !== e0[W-1:0]) begin
            errors++;
            $display("FAIL basic_idle got busy=%b vld=%b sum=%h want 0 0 %h", busy0, out_valid0, out_sum0, e0[W-1:0]);
        end
    endtask

    task automatic test_overflow();
        bit to, lb;
        logic [W:0] e0, e1;
        op_q = '{20'hFFFFF, 20'h00002};
        push_expect();
        start_job(8'd2);
        feed_ops(1'b0, 1'b0, to, lb);
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checks++;
        if (to || lb) begin
            errors++;
            $display("FAIL ovf_latency got timeout=%b latency_bad=%b want 0 0", to, lb);
        end
        checks++;
        if ({out_ovf0, out_sum0} !== e0) begin
            errors++;
            $display("FAIL ovf_wrap got %h want %h", {out_ovf0, out_sum0}, e0);
        end
        checks++;
        if ({out_ovf1, out_sum1} !== e1) begin
            errors++;
            $display("FAIL ovf_sat got %h want %h", {out_ovf1, out_sum1}, e1);
        end
        ack(1'b0);
    endtask

    task automatic test_zero_len();
        start_job(8'd0);
        checks++;
        if (out_valid0 !== 1'b1 || busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL zlen_state got vld=%b busy=%b rdy=%b want 1 1 0", out_valid0, busy0, in_ready0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_sum0 !== '0 || out_ovf0 !== 1'b0 || out_valid0 !== 1'b1 || out_sum1 !== '0) begin
                errors++;
                $display("FAIL zlen_hold cyc=%0d got sum=%h ovf=%b vld=%b want 0 0 1", i, out_sum0, out_ovf0, out_valid0);
            end
            @(negedge clk);
        end
        // start on the acknowledge cycle must not launch a new job
        ack(1'b1);
        checks++;
        if (busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL zlen_ack_start got busy=%b vld=%b want 0 0", busy0, out_valid0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL zlen_idle got busy=%b rdy=%b want 0 0", busy0, in_ready0);
        end
    endtask

    task automatic test_stall_start();
        bit to, lb;
        logic [W:0] e0, e1;
        op_q.delete();
        for (int i = 0; i < 4; i++) op_q.push_back(W'($urandom_range(0, 32'hFFFFF)));
        push_expect();
        start_job(8'd4);
        feed_ops(1'b1, 1'b1, to, lb);
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checks++;
        if (to || lb) begin
            errors++;
            $display("FAIL stall_latency got timeout=%b latency_bad=%b want 0 0", to, lb);
        end
        checks++;
        if ({out_ovf0, out_sum0} !== e0 || {out_ovf1, out_sum1} !== e1) begin
            errors++;
            $display("FAIL stall_sum got %h/%h want %h/%h", {out_ovf0, out_sum0}, {out_ovf1, out_sum1}, e0, e1);
        end
        ack(1'b0);
    endtask

    task automatic test_mid_reset();
        bit to, lb;
        logic [W:0] e0;
        op_q.delete();
        for (int i = 0; i < 4; i++) op_q.push_back(W'($urandom_range(1, 32'hFFFFF)));
        start_job(8'd4);
        in_valid = 1'b1;
        in_data  = op_q[0];
        @(negedge clk);
        in_data  = op_q[1];
        @(negedge clk);
        in_data  = op_q[2];
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags got rdy=%b vld=%b busy=%b want 0 0 0", in_ready0, out_valid0, busy0);
        end
        checks++;
        if (out_sum0 !== '0 || out_ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got sum=%h ovf=%b want 0 0", out_sum0, out_ovf0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || out_sum0 !== '0) begin
            errors++;
            $display("FAIL midrst_release got busy=%b sum=%h want 0 0", busy0, out_sum0);
        end
        in_valid = 1'b0;
        op_q = '{20'h00005};
        push_expect();
        start_job(8'd1);
        feed_ops(1'b0, 1'b0, to, lb);
        e0 = exp_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (to || lb || {out_ovf0, out_sum0} !== e0 || out_sum1 !== e0[W-1:0]) begin
            errors++;
            $display("FAIL midrst_job got %h/%h to=%b lat=%b want %h", {out_ovf0, out_sum0}, out_sum1, to, lb, e0);
        end
        ack(1'b0);
    endtask

    task automatic test_random();
        bit to, lb;
        logic [W:0] e0, e1;
        int n;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 8);
            op_q.delete();
            for (int i = 0; i < n; i++) op_q.push_back(W'($urandom_range(0, 32'hFFFFF)));
            push_expect();
            start_job(8'(n));
            feed_ops(1'b1, 1'b0, to, lb);
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            checks++;
            if (to || lb || {out_ovf0, out_sum0} !== e0 || {out_ovf1, out_sum1} !== e1) begin
                errors++;
                $display("FAIL rand_job%0d got %h/%h to=%b lat=%b want %h/%h", j, {out_ovf0, out_sum0}, {out_ovf1, out_sum1}, to, lb, e0, e1);
            end
            ack(1'b0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_stall_start();
        test_mid_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
